// File: rtl/updown_counter_p.sv
// rtl/updown_counter_p.sv - parametrised up/down counter with modulus, wrap/saturate, load and prescaler
module updown_counter_p #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // A one-bit prescaler is kept even for PRESCALE=1 so the logic stays uniform;
    // it simply never leaves zero in that case.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX      = WIDTH'(MAX_VAL);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_cnt;
    logic [WIDTH-1:0] load_clamped;
    logic             step;
    logic             at_boundary;
    logic [WIDTH-1:0] next_step_val;

    // Clamp loads so the count can never sit above the modulus.
    always_comb begin
        load_clamped = (load_val > MAX) ? MAX : load_val;
    end

    // Decide whether this edge steps and what the stepped value is.
    always_comb begin
        step          = en && (pre_cnt == PRE_LAST);
        at_boundary   = mode ? (out == '0) : (out == MAX);
        next_step_val = out;
        if (!mode) begin
            if (out == MAX) next_step_val = sat ? MAX : '0;
            else            next_step_val = out + 1'b1;
        end else begin
            if (out == '0)  next_step_val = sat ? '0 : MAX;
            else            next_step_val = out - 1'b1;
        end
    end

    // Count, prescaler and flags; priority is reset, clear, load, then step.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out     <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else if (clr) begin
            out     <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            out     <= load_clamped;
            pre_cnt <= '0;
            tc      <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (step) begin
                pre_cnt <= '0;
                out     <= next_step_val;
                if (at_boundary) begin
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                end
            end else if (en) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule
